// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the cpu memory stage and mem_ctrl: FSM state codes,
// access-size codes and the alignment/lane-enable helpers both sides rely on.
package mem_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Access-size codes carried on sel
    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    // True for a reserved size or an access not aligned to its own size.
    function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (sel)
            SEL_BYTE: bad = 1'b0;
            SEL_HALF: bad = lane[0];
            SEL_WORD: bad = (lane != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte-lane write enables for an aligned access.
    function automatic logic [3:0] lane_enables(input logic [1:0] sel, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (sel)
            SEL_BYTE: be = 4'b0001 << lane;
            SEL_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SEL_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array with four byte-lane write enables and asynchronous read.
// Contents are never reset.
module mem_array #(
    parameter int unsigned depth_log2 = 10
) (
    input  logic                  clk,
    input  logic [3:0]            be,
    input  logic [depth_log2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**depth_log2];

    // Byte-lane masked write
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_ctrl.sv
// Wait-stated memory controller: latches a cpu request in IDLE, stalls the cpu
// through WAIT, and performs the array access on the WAIT->DONE edge.
// Lane alignment assumes a 32-bit word of four byte lanes.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned width       = 32,
    parameter int unsigned depth_log2  = 10,
    parameter int unsigned wait_states = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re,
    input  logic             we,
    input  logic [1:0]       sel,
    input  logic [width-1:0] AddrIn,
    input  logic [width-1:0] DataIn,
    output logic [width-1:0] DataOut,
    output logic             mdelay,
    output logic             err
);

    localparam logic [3:0] CntLoad = 4'(wait_states - 1);

    logic [1:0]            state_q;
    logic [3:0]            cnt_q;
    logic [depth_log2+1:0] addr_q;
    logic [width-1:0]      data_q;
    logic [1:0]            sel_q;
    logic                  write_q;
    logic [width-1:0]      dout_q;
    logic                  err_q;

    logic        req;
    logic        commit;
    logic        bad;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rd_aligned;

    // Address bits above the array are ignored so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^AddrIn[width-1:depth_log2+2];

    assign req    = re | we;
    assign commit = (state_q == WAIT) && req && (cnt_q == 4'd0);
    assign bad    = is_misaligned(sel_q, addr_q[1:0]);
    // rst gates the write so a reset on the commit edge discards the access.
    assign be     = (commit && write_q && !bad && rst) ? lane_enables(sel_q, addr_q[1:0]) : 4'b0000;

    // Replicate narrow write data across lanes; enables pick the target lane(s).
    always_comb begin
        wdata = 32'(data_q);
        case (sel_q)
            SEL_BYTE: wdata = {4{wdata[7:0]}};
            SEL_HALF: wdata = {2{wdata[15:0]}};
            default:  wdata = 32'(data_q);
        endcase
    end

    // Right-align and zero-extend the addressed lane(s) of the read word.
    always_comb begin
        rd_aligned = 32'h0;
        case (sel_q)
            SEL_BYTE: rd_aligned = {24'h0, rdata[{addr_q[1:0], 3'b000} +: 8]};
            SEL_HALF: rd_aligned = {16'h0, rdata[{addr_q[1], 4'b0000} +: 16]};
            SEL_WORD: rd_aligned = rdata;
            default:  rd_aligned = 32'h0;
        endcase
    end

    mem_array #(
        .depth_log2(depth_log2)
    ) u_mem_array (
        .clk  (clk),
        .be   (be),
        .addr (addr_q[depth_log2+1:2]),
        .wdata(wdata),
        .rdata(rdata)
    );

    // Capture the request in IDLE; later input changes do not affect the access.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            addr_q  <= AddrIn[depth_log2+1:0];
            data_q  <= DataIn;
            sel_q   <= sel;
            write_q <= we;
        end
    end

    // FSM, wait counter, read data and error pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        cnt_q   <= CntLoad;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        if (bad) begin
                            err_q  <= 1'b1;
                            dout_q <= '0;
                        end else if (!write_q) begin
                            dout_q <= width'(rd_aligned);
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mdelay  = req && ((state_q == IDLE) || (state_q == WAIT));
    assign DataOut = dout_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized accesses
// compared against a byte-addressed behavioural model.
module tb_mem_ctrl;

    localparam int W  = 32;
    localparam int DL = 10;
    localparam int WS = 2;
    localparam int NBYTES = 4 << DL;

    logic        clk = 1'b0;
    logic        rst;
    logic        re;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] AddrIn;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        mdelay;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem_m [NBYTES];
    logic [31:0] dout_m;

    always #5 clk = ~clk;

    mem_ctrl #(
        .width      (W),
        .depth_log2 (DL),
        .wait_states(WS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .re     (re),
        .we     (we),
        .sel    (sel),
        .AddrIn (AddrIn),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .mdelay (mdelay),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit misal(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic int size_of(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    // Behavioural effect of one completed access on the model
    task automatic model_access(input logic w, input logic [1:0] s, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] exp_d,
                                output logic exp_e);
        int b;
        b = int'(a) % NBYTES;
        exp_e = 1'b0;
        if (misal(s, a)) begin
            exp_e  = 1'b1;
            dout_m = 32'h0;
        end else if (w) begin
            for (int i = 0; i < size_of(s); i++) mem_m[b + i] = d[8*i +: 8];
        end else begin
            dout_m = 32'h0;
            for (int i = 0; i < size_of(s); i++) dout_m[8*i +: 8] = mem_m[b + i];
        end
        exp_d = dout_m;
    endtask

    // One full access; called and returns at posedge+1 with the DUT in IDLE.
    task automatic access(input logic r, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit keep, input bit scramble);
        logic [31:0] exp_d;
        logic        exp_e;
        model_access(w, s, a, d, exp_d, exp_e);
        re = r; we = w; sel = s; AddrIn = a; DataIn = d;
        for (int k = 0; k <= WS; k++) begin
            @(negedge clk);
            check("mdelay_busy", 32'(mdelay), 32'd1);
            @(posedge clk); #1;
            if (scramble) begin
                AddrIn = $urandom; DataIn = $urandom; sel = 2'($urandom_range(0, 3));
            end
        end
        @(negedge clk);
        check("mdelay_done", 32'(mdelay), 32'd0);
        check("err_done", 32'(err), 32'(exp_e));
        check("dout_done", DataOut, exp_d);
        if (keep) begin
            re = r; we = w;
            @(posedge clk); #1;
        end else begin
            re = 1'b0; we = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            check("err_pulse_end", 32'(err), 32'd0);
            check("mdelay_idle", 32'(mdelay), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] saved;
        rst = 1'b0; re = 1'b0; we = 1'b0; sel = 2'b00; AddrIn = '0; DataIn = '0;
        dout_m = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_dout", DataOut, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mdelay_lo", 32'(mdelay), 32'd0);
        re = 1'b1;
        #1;
        check("rst_mdelay_hi", 32'(mdelay), 32'd1);
        re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Preload the low 32 words
        for (int i = 0; i < 32; i++) access(1'b0, 1'b1, 2'b10, 32'(i * 4), $urandom, 1'b0, 1'b0);

        // Word write / read
        access(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        access(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 1'b0);
        check("word_rd_const", DataOut, 32'hDEADBEEF);

        // Byte write into a word, word and byte read back
        access(1'b0, 1'b1, 2'b10, 32'h10, 32'h11223344, 1'b0, 1'b0);
        access(1'b0, 1'b1, 2'b00, 32'h13, 32'h000000AA, 1'b0, 1'b0);
        access(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 1'b0);
        check("byte_merge_const", DataOut, 32'hAA223344);
        access(1'b1, 1'b0, 2'b00, 32'h13, 32'h0, 1'b0, 1'b0);
        check("byte_rd_const", DataOut, 32'h000000AA);

        // Misaligned and reserved accesses, then memory unchanged
        access(1'b1, 1'b0, 2'b01, 32'h11, 32'h0, 1'b0, 1'b0);
        access(1'b0, 1'b1, 2'b11, 32'h10, 32'h55555555, 1'b0, 1'b0);
        access(1'b0, 1'b1, 2'b10, 32'h12, 32'h66666666, 1'b0, 1'b0);
        access(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 1'b0);
        check("misal_nowrite", DataOut, 32'hAA223344);

        // Back-to-back reads with re held high
        access(1'b1, 1'b0, 2'b10, 32'h20, 32'h0, 1'b1, 1'b0);
        access(1'b1, 1'b0, 2'b01, 32'h22, 32'h0, 1'b0, 1'b0);

        // Reset on the commit edge of a write
        access(1'b1, 1'b0, 2'b10, 32'h40, 32'h0, 1'b0, 1'b0);
        saved = dout_m;
        re = 1'b0; we = 1'b1; sel = 2'b10; AddrIn = 32'h40; DataIn = ~saved;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        we = 1'b0;
        @(negedge clk);
        check("midrst_dout", DataOut, 32'h0);
        check("midrst_err", 32'(err), 32'd0);
        rst = 1'b1;
        dout_m = 32'h0;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 2'b10, 32'h40, 32'h0, 1'b0, 1'b0);
        check("midrst_nowrite", DataOut, saved);

        // Address wrap onto word 0
        access(1'b0, 1'b1, 2'b10, 32'h1000, 32'hC0FFEE01, 1'b0, 1'b0);
        access(1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0, 1'b0);
        check("wrap_const", DataOut, 32'hC0FFEE01);

        // Abort by dropping re during WAIT
        re = 1'b1; we = 1'b0; sel = 2'b10; AddrIn = 32'h10;
        @(posedge clk); #1;
        re = 1'b0;
        @(negedge clk);
        check("abort_mdelay", 32'(mdelay), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_dout", DataOut, 32'hC0FFEE01);
        check("abort_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        // Randomized accesses over the preloaded region with aliasing upper bits
        for (int n = 0; n < 250; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = (32'($urandom_range(0, 15)) << 12) | 32'($urandom_range(0, 127));
            access(kind != 1, kind != 0, 2'($urandom_range(0, 3)), a, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
